systolic_feeder_2x2: RTL
========================

// Module: systolic_feeder_2x2
// PURPOSE
//  Upstream driver for the 2x2 systolic array; performs the role the array bench plays by hand.
//  Accepts one A/B matrix-pair per handshake.
//  Emits the skewed per-cycle weight/data slot pattern on the array's a00..a11 / b00..b11 / in_valid inputs.
//  Sets overlap at a 2-cycle issue period, so back-to-back sets stream with no gaps.
// PARAMETERS
//  DATA_WIDTH  4  element width (unsigned)
//  TAIL        1  extra in_valid cycles held after the last data slot of the final in-flight set (0..7)
// PORTS
//  clk        in   1     clock; single clock domain
//  rst        in   1     synchronous reset, active-high
//  s_valid    in   1     upstream set valid
//  s_ready    out  1     feeder can accept a set this cycle
//  s_a        in   4*DW  {A11,A10,A01,A00}, A00 at [DW-1:0]
//  s_b        in   4*DW  {B11,B10,B01,B00}, B00 at [DW-1:0]
//  a00,a01,a10,a11  out  DW  array data slots
//  b00,b01,b10,b11  out  DW  array weight slots
//  in_valid   out  1     array input valid
//  busy       out  1     any set in flight, or the tail counter is non-zero
// BEHAVIOUR
//  Interface: one clock clk; rst is synchronous, active-high.
//  Reset: all a*/b* = 0; in_valid = 0; busy = 0; s_ready = 0 during rst, 1 the first cycle after.
//    All in-flight sets and the tail counter are discarded.
//  Accept: s_valid && s_ready in cycle c captures s_a/s_b; that set's issue cycle is t = c+1.
//  Spacing: s_ready = 0 in the cycle immediately after an accept; otherwise 1.
//    Minimum spacing between accepts is therefore 2 cycles; s_ready is not a function of s_valid.
//  Slot schedule, all outputs registered, per set issued at t:
//    t  : b01=B01
//    t+1: b00=B00, b10=B10
//    t+2: b11=B11, a00=A00
//    t+3: a01=A01, a10=A10
//    t+4: a11=A11
//  Any output slot not driven by some set in a cycle is 0. With 2-cycle spacing no two sets drive one port in one cycle.
//  Implementation: a 5-deep shift pipeline of set registers plus a valid bit per stage.
//    At most 3 sets are in flight.
//  in_valid: 1 in any cycle where some set is at offset t+2..t+4.
//    Also 1 for TAIL cycles after the last such cycle.
//    A new set reaching t+2 during the tail keeps it 1 continuously; the tail counter restarts after that set's t+4.
//  busy = OR of stage valids, or tail count != 0.
//  Latency: accept at c, first slot at c+1, last slot at c+5.
//    in_valid falls after c+5+TAIL when no further set is accepted.
//  Edge cases:
//    - s_valid held high continuously: accepts on alternate cycles; outputs show the periodic pattern.
//    - s_valid dropped with no accept: no state change; the input is not sampled.
//    - rst mid-stream: the next cycle shows all outputs 0 and in_valid 0; partial sets are never resumed.
//    - Accept in the same cycle rst deasserts is impossible because s_ready=0 under rst.
// TESTING
//  T1 reset: rst=1 for 3 cycles with s_valid=1 -> s_ready=0, all a*/b*=0, in_valid=0, busy=0.
//  T2 single set, A={A00=5,A01=5,A10=15,A11=14}, B={B00=7,B01=11,B10=2,B11=9}, accepted at c=0:
//     - c1: b01=11
//     - c2: b00=7, b10=2
//     - c3: b11=9, a00=5, in_valid=1
//     - c4: a01=5, a10=15
//     - c5: a11=14
//     - c6: in_valid=1 (TAIL); all slots 0
//     - c7: in_valid=0, busy=0
//  T3 three sets, s_valid held high: accepts at c=0,2,4; s_ready toggles 1,0,1,0,1.
//     Set2 (B01=2, B11=8): c3 shows b01=2 together with b11=9 and a00=5 from set1.
//     in_valid is continuous from c3 to c10.
//  T4 gapped sets at c=0 and c=8: in_valid drops after c6; second burst c11..c14; slots 0 in between.
//  T5 rst asserted at c=3 of T2: c4 all outputs 0, in_valid=0, busy=0, s_ready=0; c5 s_ready=1.
//  T6 TAIL=0, all-ones data (15) -> slots carry 15 with no truncation; in_valid high exactly c3..c5.

Source files
------------

// File: rtl/systolic_feeder_2x2_if.sv
// systolic_feeder_2x2_if: upstream set handshake
// one A/B matrix pair per valid/ready transfer
interface systolic_feeder_2x2_if #(
  parameter int DATA_WIDTH = 4
);
  logic                    s_valid;
  logic                    s_ready;
  logic [4*DATA_WIDTH-1:0] s_a;
  logic [4*DATA_WIDTH-1:0] s_b;

  modport master (
    output s_valid,
    output s_a,
    output s_b,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_a,
    input  s_b,
    output s_ready
  );
endinterface

// File: rtl/systolic_feeder_2x2.sv
// systolic_feeder_2x2: skews A/B sets onto the 2x2 array
// slot inputs, sets overlap at a 2-cycle issue period
module systolic_feeder_2x2 #(
  parameter int DATA_WIDTH = 4,
  parameter int TAIL       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  systolic_feeder_2x2_if.slave  s,
  output logic [DATA_WIDTH-1:0] a00,
  output logic [DATA_WIDTH-1:0] a01,
  output logic [DATA_WIDTH-1:0] a10,
  output logic [DATA_WIDTH-1:0] a11,
  output logic [DATA_WIDTH-1:0] b00,
  output logic [DATA_WIDTH-1:0] b01,
  output logic [DATA_WIDTH-1:0] b10,
  output logic [DATA_WIDTH-1:0] b11,
  output logic                  in_valid,
  output logic                  busy
);
  localparam int DW = DATA_WIDTH;
  localparam logic [2:0] TAIL_W = 3'(TAIL);

  // stage k valid = a set sits at issue offset k
  logic [4:0] v_q;
  logic [4:0] v_d;
  logic [2:0] tail_q;
  logic [2:0] tail_d;
  logic       ready_q;
  logic       acc;
  logic       mid_q;
  logic       mid_d;

  // data stages keep only fields still to be emitted
  logic [4*DW-1:0] q0_a;
  logic [DW-1:0]   q0_b00;
  logic [DW-1:0]   q0_b10;
  logic [DW-1:0]   q0_b11;
  logic [4*DW-1:0] q1_a;
  logic [DW-1:0]   q1_b11;
  logic [DW-1:0]   q2_a01;
  logic [DW-1:0]   q2_a10;
  logic [DW-1:0]   q2_a11;
  logic [DW-1:0]   q3_a11;

  logic [DW-1:0] a00_d;
  logic [DW-1:0] a01_d;
  logic [DW-1:0] a10_d;
  logic [DW-1:0] a11_d;
  logic [DW-1:0] b00_d;
  logic [DW-1:0] b01_d;
  logic [DW-1:0] b10_d;
  logic [DW-1:0] b11_d;

  assign s.s_ready = ready_q & ~rst;

  // next valids, tail count and slot values
  always_comb begin
    acc   = s.s_valid & s.s_ready;
    v_d   = {v_q[3:0], acc};
    mid_q = |v_q[4:2];
    mid_d = |v_d[4:2];
    if (mid_q)
      tail_d = TAIL_W;
    else if (tail_q != 3'd0)
      tail_d = tail_q - 3'd1;
    else
      tail_d = 3'd0;
    b01_d = acc    ? s.s_b[DW +: DW] : '0;
    b00_d = v_q[0] ? q0_b00 : '0;
    b10_d = v_q[0] ? q0_b10 : '0;
    b11_d = v_q[1] ? q1_b11 : '0;
    a00_d = v_q[1] ? q1_a[0 +: DW] : '0;
    a01_d = v_q[2] ? q2_a01 : '0;
    a10_d = v_q[2] ? q2_a10 : '0;
    a11_d = v_q[3] ? q3_a11 : '0;
  end

  // control state and registered array outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      tail_q   <= '0;
      ready_q  <= 1'b0;
      in_valid <= 1'b0;
      busy     <= 1'b0;
      a00      <= '0;
      a01      <= '0;
      a10      <= '0;
      a11      <= '0;
      b00      <= '0;
      b01      <= '0;
      b10      <= '0;
      b11      <= '0;
    end else begin
      v_q      <= v_d;
      tail_q   <= tail_d;
      ready_q  <= ~acc;
      in_valid <= mid_d | (tail_d != 3'd0);
      busy     <= (|v_d) | (tail_d != 3'd0);
      a00      <= a00_d;
      a01      <= a01_d;
      a10      <= a10_d;
      a11      <= a11_d;
      b00      <= b00_d;
      b01      <= b01_d;
      b10      <= b10_d;
      b11      <= b11_d;
    end
  end

  // data shift pipeline, qualified by the stage valids
  always_ff @(posedge clk) begin
    q0_a   <= s.s_a;
    q0_b00 <= s.s_b[0 +: DW];
    q0_b10 <= s.s_b[2*DW +: DW];
    q0_b11 <= s.s_b[3*DW +: DW];
    q1_a   <= q0_a;
    q1_b11 <= q0_b11;
    q2_a01 <= q1_a[DW +: DW];
    q2_a10 <= q1_a[2*DW +: DW];
    q2_a11 <= q1_a[3*DW +: DW];
    q3_a11 <= q2_a11;
  end
endmodule
